// File: rtl/arb_request_queue_pkg.sv
// Shared types for the arbiter request queue: packet layout,
// priority encoding and the priority-to-weight mapping.
package arb_pkg;

    localparam int PKT_DATA_W = 8;
    localparam int PKT_TS_W   = 32;

    localparam logic [7:0] WEIGHT_LO  = 8'd1;
    localparam logic [7:0] WEIGHT_MED = 8'd2;
    localparam logic [7:0] WEIGHT_HI  = 8'd3;

    typedef enum logic [2:0] {
        PRIO_LO  = 3'b001,
        PRIO_MED = 3'b010,
        PRIO_HI  = 3'b100
    } priority_t;

    // prior is kept raw so malformed encodings survive to the output
    typedef struct packed {
        logic [7:0]            requestor_id;
        logic [PKT_DATA_W-1:0] data;
        logic [2:0]            prior;
        logic [PKT_TS_W-1:0]   time_present;
    } packet_t;

    function automatic logic [7:0] prior_to_weight(input logic [2:0] p);
        logic [7:0] w;
        case (p)
            PRIO_MED: w = WEIGHT_MED;
            PRIO_HI:  w = WEIGHT_HI;
            default:  w = WEIGHT_LO;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/arb_request_queue_if.sv
// Bundle between the request queue, its producers, the arbiter
// and the downstream consumer.
interface arb_request_queue_if #(
    parameter int REQUESTORS = 4,
    parameter int DATA_W     = 8,
    parameter int TS_W       = 32
);
    logic [REQUESTORS-1:0]        in_valid;
    logic [REQUESTORS-1:0]        in_ready;
    logic [REQUESTORS*DATA_W-1:0] in_data;
    logic [REQUESTORS*3-1:0]      in_prior;
    logic [REQUESTORS-1:0]        req;
    logic [REQUESTORS*8-1:0]      weights;
    logic [REQUESTORS*TS_W-1:0]   head_time;
    logic [REQUESTORS-1:0]        grant;
    logic                         out_valid;
    logic                         out_ready;
    logic [7:0]                   out_id;
    logic [DATA_W-1:0]            out_data;
    logic [2:0]                   out_prior;
    logic [TS_W-1:0]              out_time;

    modport slave (
        input  in_valid, in_data, in_prior, grant, out_ready,
        output in_ready, req, weights, head_time,
        output out_valid, out_id, out_data, out_prior, out_time
    );

    modport master (
        output in_valid, in_data, in_prior, grant, out_ready,
        input  in_ready, req, weights, head_time,
        input  out_valid, out_id, out_data, out_prior, out_time
    );
endinterface

// File: rtl/arb_request_queue_fifo.sv
// Single-requestor packet FIFO; head is valid whenever empty_o is low.
module arb_pkt_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  packet_t din_i,
    output logic    full_o,
    output logic    empty_o,
    output packet_t head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    packet_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + PTR_W'(1);
        if (pop_ok)  rd_d = rd_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage needs no reset: it is only observed through a non-empty count
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/arb_request_queue.sv
// Per-requestor packet queues feeding a FCFS weighted round-robin
// arbiter; forwards the granted head downstream.
module arb_request_queue
    import arb_pkg::*;
#(
    parameter int REQUESTORS = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_W     = PKT_DATA_W,
    parameter int TS_W       = PKT_TS_W
) (
    input logic               clk,
    input logic               reset,
    arb_request_queue_if.slave bus
);
    localparam int IDX_W = (REQUESTORS > 1) ? $clog2(REQUESTORS) : 1;

    logic [TS_W-1:0]       ts_cnt_q, ts_cnt_d;
    logic                  err_q, err_d;
    logic [REQUESTORS-1:0] push, pop, full, empty;
    packet_t               head [REQUESTORS];
    packet_t               sel;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_onehot, gnt_multi, sel_ok;

    for (genvar g = 0; g < REQUESTORS; g++) begin : g_q
        packet_t din;
        assign din = '{
            requestor_id: 8'(g),
            data:         bus.in_data[g*DATA_W +: DATA_W],
            prior:        bus.in_prior[g*3 +: 3],
            time_present: ts_cnt_q
        };
        assign push[g]         = bus.in_valid[g] & ~full[g];
        assign bus.in_ready[g] = ~full[g];
        assign bus.req[g]      = ~empty[g];
        assign bus.weights[g*8 +: 8] =
            empty[g] ? 8'd0 : prior_to_weight(head[g].prior);
        assign bus.head_time[g*TS_W +: TS_W] =
            empty[g] ? '0 : head[g].time_present;

        arb_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst_i   (reset),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (din),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .head_o  (head[g])
        );
    end

    // a zero, multi-hot or empty-queue grant forwards nothing
    always_comb begin
        gnt_onehot = $onehot(bus.grant);
        gnt_multi  = ~$onehot0(bus.grant);
        gnt_idx    = '0;
        for (int i = 0; i < REQUESTORS; i++) begin
            if (bus.grant[i]) gnt_idx = i[IDX_W-1:0];
        end
        sel    = head[gnt_idx];
        sel_ok = gnt_onehot & ~empty[gnt_idx];

        bus.out_valid = sel_ok;
        bus.out_id    = '0;
        bus.out_data  = '0;
        bus.out_prior = '0;
        bus.out_time  = '0;
        pop           = '0;
        if (sel_ok) begin
            bus.out_id    = 8'(gnt_idx);
            bus.out_data  = sel.data;
            bus.out_prior = sel.prior;
            bus.out_time  = sel.time_present;
            if (bus.out_ready) pop = bus.grant;
        end
    end

    assign ts_cnt_d = ts_cnt_q + TS_W'(1);
    assign err_d    = err_q | gnt_multi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_arb_request_queue.sv
// Self-checking bench for arb_request_queue: directed scenarios
// followed by random traffic against a queue-based reference model.
module tb_arb_request_queue;

    localparam int R  = 4;
    localparam int D  = 4;
    localparam int DW = 8;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arb_request_queue_if #(.REQUESTORS(R), .DATA_W(DW), .TS_W(TW)) bus ();

    arb_request_queue #(
        .REQUESTORS(R), .DEPTH(D), .DATA_W(DW), .TS_W(TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  data;
        logic [2:0]  prior;
        logic [31:0] t;
    } ent_t;

    ent_t        mq [R][$];
    logic [31:0] m_ts;
    logic        m_err;
    int          tests = 0;
    int          fails = 0;
    bit          cur_v;
    int          cur_idx;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wgt(input logic [2:0] p);
        if (p == 3'b010) return 2;
        if (p == 3'b100) return 3;
        return 1;
    endfunction

    task automatic check_all();
        int nb;
        for (int i = 0; i < R; i++) begin
            chk($sformatf("req%0d", i), 64'(bus.req[i]), 64'(mq[i].size() != 0));
            chk($sformatf("in_ready%0d", i), 64'(bus.in_ready[i]),
                64'(mq[i].size() < D));
            if (mq[i].size() != 0) begin
                chk($sformatf("weight%0d", i), 64'(bus.weights[i*8 +: 8]),
                    64'(wgt(mq[i][0].prior)));
                chk($sformatf("head_time%0d", i),
                    64'(bus.head_time[i*TW +: TW]), 64'(mq[i][0].t));
            end else begin
                chk($sformatf("weight%0d", i), 64'(bus.weights[i*8 +: 8]), 64'd0);
                chk($sformatf("head_time%0d", i),
                    64'(bus.head_time[i*TW +: TW]), 64'd0);
            end
        end
        nb = $countones(bus.grant);
        cur_idx = 0;
        for (int i = 0; i < R; i++) if (bus.grant[i]) cur_idx = i;
        cur_v = (nb == 1) && (mq[cur_idx].size() != 0);
        chk("out_valid", 64'(bus.out_valid), 64'(cur_v));
        if (cur_v) begin
            chk("out_id", 64'(bus.out_id), 64'(cur_idx));
            chk("out_data", 64'(bus.out_data), 64'(mq[cur_idx][0].data));
            chk("out_prior", 64'(bus.out_prior), 64'(mq[cur_idx][0].prior));
            chk("out_time", 64'(bus.out_time), 64'(mq[cur_idx][0].t));
        end else begin
            chk("out_id", 64'(bus.out_id), 64'd0);
            chk("out_data", 64'(bus.out_data), 64'd0);
            chk("out_prior", 64'(bus.out_prior), 64'd0);
            chk("out_time", 64'(bus.out_time), 64'd0);
        end
        chk("ts_cnt", 64'(dut.ts_cnt_q), 64'(m_ts));
        chk("err_flag", 64'(dut.err_q), 64'(m_err));
    endtask

    // check outputs, advance the model across one edge, return at negedge
    task automatic tick();
        int sz [R];
        #1;
        check_all();
        for (int i = 0; i < R; i++) sz[i] = mq[i].size();
        for (int i = 0; i < R; i++) begin
            if (bus.in_valid[i] && sz[i] < D) begin
                ent_t e;
                e.data  = bus.in_data[i*DW +: DW];
                e.prior = bus.in_prior[i*3 +: 3];
                e.t     = m_ts;
                mq[i].push_back(e);
            end
        end
        if (cur_v && bus.out_ready) void'(mq[cur_idx].pop_front());
        if ($countones(bus.grant) > 1) m_err = 1'b1;
        @(posedge clk);
        m_ts = m_ts + 32'd1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_prior  = '0;
        bus.grant     = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < R; i++) mq[i].delete();
        m_ts  = '0;
        m_err = 1'b0;
    endtask

    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push1(input int q, input logic [7:0] d,
                         input logic [2:0] p);
        bus.in_valid = '0;
        bus.in_valid[q] = 1'b1;
        bus.in_data[q*DW +: DW] = d;
        bus.in_prior[q*3 +: 3] = p;
    endtask

    initial begin
        idle_inputs();
        model_clear();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;

        repeat (5) tick();
        chk("ts_after_5", 64'(dut.ts_cnt_q), 64'd5);
        repeat (2) tick();

        push1(2, 8'hA5, 3'b010);
        tick();
        bus.in_valid = '0;
        #1;
        chk("req_after_push", 64'(bus.req), 64'b0100);
        chk("weight2_med", 64'(bus.weights[16 +: 8]), 64'd2);
        chk("head_time2", 64'(bus.head_time[64 +: 32]), 64'd7);
        tick();
        bus.grant = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        chk("a5_id", 64'(bus.out_id), 64'd2);
        chk("a5_data", 64'(bus.out_data), 64'hA5);
        chk("a5_time", 64'(bus.out_time), 64'd7);
        tick();
        bus.grant = '0;
        bus.out_ready = 1'b0;
        tick();

        for (int k = 0; k < D; k++) begin
            push1(0, 8'(8'h10 + k), 3'(3'b001 << (k % 3)));
            tick();
        end
        push1(0, 8'hEE, 3'b100);
        #1 chk("full_q0_ready", 64'(bus.in_ready[0]), 64'd0);
        tick();
        bus.in_valid = '0;
        bus.grant = 4'b0001;
        bus.out_ready = 1'b1;
        repeat (D) tick();
        bus.grant = '0;
        bus.out_ready = 1'b0;
        tick();

        for (int k = 0; k < D; k++) begin
            push1(1, 8'(8'h30 + k), 3'b100);
            tick();
        end
        push1(1, 8'h55, 3'b001);
        bus.grant = 4'b0010;
        bus.out_ready = 1'b1;
        tick();
        push1(1, 8'h66, 3'b010);
        bus.grant = '0;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = '0;
        #1 chk("q1_refilled", 64'(bus.in_ready[1]), 64'd0);
        tick();
        bus.grant = 4'b0010;
        bus.out_ready = 1'b1;
        repeat (D) tick();
        bus.grant = '0;
        tick();

        bus.in_valid = 4'b0011;
        bus.in_data = '0;
        bus.in_prior = 12'b000_000_000_000;
        tick();
        bus.in_valid = '0;
        bus.grant = 4'b0011;
        bus.out_ready = 1'b1;
        tick();
        bus.grant = '0;
        #1 chk("err_sticky", 64'(dut.err_q), 64'd1);
        tick();
        bus.grant = 4'b1000;
        tick();
        bus.grant = 4'b0001;
        tick();
        bus.grant = 4'b0010;
        tick();
        idle_inputs();
        tick();

        repeat (400) begin
            int r;
            bus.in_valid = 4'($urandom);
            bus.in_data  = 32'($urandom);
            bus.in_prior = 12'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7) bus.grant = 4'(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) bus.grant = '0;
            else bus.grant = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle_inputs();
        async_reset();
        for (int k = 0; k < 3; k++) begin
            push1(2, 8'(8'hC0 + k), 3'b100);
            tick();
        end
        bus.in_valid = '0;
        bus.grant = 4'b0100;
        bus.out_ready = 1'b0;
        #1 chk("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        async_reset();
        #1 chk("post_reset_ts", 64'(dut.ts_cnt_q), 64'd0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arb_request_queue.md
Name: arb_request_queue

Overview:
- Front-end stage directly upstream of the FCFS weighted round-robin arbiter.
- Buffers incoming packets per requestor, stamps each with its arrival time, and drives the arbiter's req and weights from each queue head.
- Forwards the head packet of the granted requestor downstream over a valid/ready handshake and pops it on transfer.

Parameters:
- REQUESTORS, 4, number of requestor queues.
- DEPTH, 4, entries per queue; power of two, >= 2.
- DATA_W, 8, packet payload width.
- TS_W, 32, timestamp width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  REQUESTORS  per-requestor push request.
- in_ready  out  REQUESTORS  per-requestor queue not full.
- in_data  in  REQUESTORS*DATA_W  payload; slice i belongs to requestor i.
- in_prior  in  REQUESTORS*3  priority per requestor, one-hot: LO=001, MED=010, HI=100.
- req  out  REQUESTORS  to arbiter; bit i = queue i non-empty.
- weights  out  REQUESTORS*8  to arbiter; head-entry weight per requestor.
- head_time  out  REQUESTORS*TS_W  arrival timestamp of each head entry.
- grant  in  REQUESTORS  one-hot grant from arbiter.
- out_valid  out  1  granted head packet available.
- out_ready  in  1  downstream accepts.
- out_id  out  8  index of the granted requestor.
- out_data  out  DATA_W  payload of the granted head.
- out_prior  out  3  priority of the granted head.
- out_time  out  TS_W  arrival timestamp of the granted head.

Behaviour:
- Free-running TS_W-bit counter ts_cnt: 0 after reset, +1 every clk, wraps to 0 after all-ones.
- Push: in_valid[i] && in_ready[i] at edge N writes {in_data slice, in_prior slice, ts_cnt} into queue i. req[i] is asserted from cycle N+1. There is no bypass.
- in_ready[i] = (count[i] != DEPTH). It is combinational from registered state only and does not depend on pops in the same cycle.
- Weights from head priority:
  - LO -> 1, MED -> 2, HI -> 3.
  - Any non-one-hot value (including 000) is stored as-is and weighted 1.
  - weights[i] and head_time[i] are 0 when queue i is empty.
- Output select:
  - out_valid = grant is exactly one-hot AND req of the granted index is 1.
  - out_* fields are combinational from that queue's head.
  - When out_valid=0, out_id/out_data/out_prior/out_time are 0.
- Pop: out_valid && out_ready at an edge removes the granted head. The next entry, if any, becomes head the following cycle.
- Simultaneous push and pop on the same queue in one cycle is legal:
  - count is unchanged.
  - Order is preserved (FIFO).
  - Allowed when full: in_ready is already 0, so no push occurs.
- Protocol errors:
  - grant with more than one bit set: out_valid=0, no pop, sticky internal flag for assertion.
  - grant to an empty queue: out_valid=0, no state change.
- Queues are independent; pushes to different requestors in the same cycle all succeed.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset, asynchronous and at any time including mid-transfer:
  - All queues are emptied and ts_cnt returns to 0.
  - Output values during reset: req=0, weights=0, head_time=0, out_valid=0, in_ready all 1.
  - In-flight packets are discarded.
- Per-queue order is FIFO only. Cross-requestor ordering (FCFS) is the arbiter's job, using head_time.

Decomposition:
- Package arb_pkg holds:
  - priority_t, a 3-bit one-hot enum LO/MED/HI.
  - packet_t struct {requestor_id[7:0], data, prior, time_present[TS_W-1:0]}.
  - function prior_to_weight.
  - constants WEIGHT_LO/MED/HI = 1/2/3.
- One sub-module, arb_pkt_fifo: a single synchronous FIFO of packet_t with push/pop/full/empty/head outputs. It is instantiated REQUESTORS times in a generate loop.
- The top level holds ts_cnt, the weight mapping, grant decode/mux and the protocol-error flag.

Test Plan:
- Reset then idle -> req=0000, in_ready=1111, out_valid=0; ts_cnt=5 five cycles after reset release.
- Push one MED packet data=0xA5 to requestor 2 at ts_cnt=7 -> next cycle req=0100, weights[2]=2, head_time[2]=7. With grant=0100 and out_ready=1: out_id=2, out_data=0xA5, out_time=7, then req=0000.
- Fill requestor 0 with 4 packets (DEPTH=4) -> in_ready[0]=0, a fifth push is ignored. Then pop with out_ready=1 for 4 cycles -> data emerges in push order, in_ready[0]=1 after the first pop.
- Full queue 1, grant=0010, out_ready=1 while in_valid[1]=1 -> same cycle pops one, push blocked; next cycle push accepted, count back to 4, order intact.
- grant=0011 with queues 0 and 1 non-empty -> out_valid=0, no pop, error flag set. grant=1000 with queue 3 empty -> out_valid=0, no state change.
- Queue holding 3 entries, assert reset mid-transfer with out_valid=1 -> out_valid, req, weights drop asynchronously; after release all queues are empty and ts_cnt restarts at 0.
